// File: rtl/dmem_ctrl_if.sv
// Data-SRAM bus between the MEM-stage access controller and the bus bridge.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              data_sram_req_o;
    logic              data_sram_wr_o;
    logic [1:0]        data_sram_size_o;
    logic [ADDR_W-1:0] data_sram_addr_o;
    logic [DATA_W-1:0] data_sram_wdata_o;
    logic [STRB_W-1:0] data_sram_wstrb_o;
    logic              data_sram_addr_ok_i;
    logic              data_sram_data_ok_i;
    logic [DATA_W-1:0] data_sram_rdata_i;

    // Controller side: issues the request, receives accept/response.
    modport master (
        output data_sram_req_o,
        output data_sram_wr_o,
        output data_sram_size_o,
        output data_sram_addr_o,
        output data_sram_wdata_o,
        output data_sram_wstrb_o,
        input  data_sram_addr_ok_i,
        input  data_sram_data_ok_i,
        input  data_sram_rdata_i
    );

    // Bridge side: accepts the request, returns the response beat.
    modport slave (
        input  data_sram_req_o,
        input  data_sram_wr_o,
        input  data_sram_size_o,
        input  data_sram_addr_o,
        input  data_sram_wdata_o,
        input  data_sram_wstrb_o,
        output data_sram_addr_ok_i,
        output data_sram_data_ok_i,
        output data_sram_rdata_i
    );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data-SRAM access sequencer: one outstanding transaction on a
// req/addr_ok/data_ok bus, stall generation, read capture and flush cancel.
module dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wr_i,
    input  logic [1:0]            cpu_size_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W-1:0]     cpu_wdata_i,
    input  logic [DATA_W/8-1:0]   cpu_wstrb_i,
    input  logic                  pipe_hold_i,
    input  logic                  flush_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  done_o,
    output logic                  stall_o,
    dmem_ctrl_if.master           bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        CANCEL = 3'd4
    } state_t;

    state_t state;
    // Set when a flush hits while the request is still waiting for addr_ok;
    // the request cannot be withdrawn, so its response is discarded later.
    logic   cancel_q;

    // Stall is decoded from the current state so the pipeline freezes in the
    // same cycle the access is requested; a flush or reset always releases it.
    always_comb begin
        stall_o = 1'b0;
        unique case (state)
            IDLE:      stall_o = cpu_req_i;
            REQ, WAIT: stall_o = 1'b1;
            CANCEL:    stall_o = cpu_req_i;
            default:   stall_o = 1'b0;
        endcase
        if (flush_i || rst) begin
            stall_o = 1'b0;
        end
    end

    // Transaction sequencer with registered bus fields, done flag and read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            cancel_q              <= 1'b0;
            bus.data_sram_req_o   <= 1'b0;
            bus.data_sram_wr_o    <= 1'b0;
            bus.data_sram_size_o  <= '0;
            bus.data_sram_addr_o  <= '0;
            bus.data_sram_wdata_o <= '0;
            bus.data_sram_wstrb_o <= '0;
            rdata_o               <= '0;
            done_o                <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // data_ok here is a protocol error and is ignored.
                    if (cpu_req_i && !flush_i) begin
                        bus.data_sram_req_o   <= 1'b1;
                        bus.data_sram_wr_o    <= cpu_wr_i;
                        bus.data_sram_size_o  <= cpu_size_i;
                        bus.data_sram_addr_o  <= cpu_addr_i;
                        bus.data_sram_wdata_o <= cpu_wdata_i;
                        bus.data_sram_wstrb_o <= cpu_wstrb_i;
                        cancel_q              <= 1'b0;
                        state                 <= REQ;
                    end
                end
                REQ: begin
                    // Fields stay stable until the bridge accepts them.
                    if (bus.data_sram_addr_ok_i) begin
                        bus.data_sram_req_o <= 1'b0;
                        cancel_q            <= 1'b0;
                        state               <= (flush_i || cancel_q) ? CANCEL : WAIT;
                    end else if (flush_i) begin
                        cancel_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.data_sram_data_ok_i) begin
                        if (flush_i || cancel_q) begin
                            state <= IDLE;
                        end else begin
                            // Stores capture the bus value too; it is unused.
                            rdata_o <= bus.data_sram_rdata_i;
                            done_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end else if (flush_i) begin
                        state <= CANCEL;
                    end
                end
                DONE: begin
                    // Leave on the same edge the pipeline advances, so the
                    // still-asserted cpu_req_i is never re-issued.
                    if (!pipe_hold_i || flush_i) begin
                        done_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CANCEL: begin
                    if (bus.data_sram_data_ok_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
